packet_transfer_scheduler: RTL and testbench

//  Picks completed packets from the packet buffer's NUM_SLOTS slots, round-robin, and feeds them one at a time
//  to packet_transfer_buffer. It holds each packet until the buffer reports transfered_packet_completed,

---
 rtl/packet_types.sv | 17 +
 rtl/packet_rr_arbiter.sv | 30 +++
 rtl/packet_transfer_scheduler.sv | 116 +++++++++++
 tb/tb_packet_transfer_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_types.sv
// Shared packet-controller types: the slot element format and the
// transfer scheduler's state encoding.
package packet_types;

   typedef struct packed {
      logic [3:0]  dest;
      logic [7:0]  length;
      logic [31:0] data;
   } packet_element_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FREE = 2'd2
   } transfer_sched_state_t;

endpackage

// File: rtl/packet_rr_arbiter.sv
// Combinational round-robin arbiter: returns the first requesting index
// strictly after i_ptr, wrapping modulo N (N must be a power of two).
module packet_rr_arbiter #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_grant_idx,
   output logic         o_grant_valid
);

   logic [W-1:0] w_cand;

   // Scan ptr+1 .. ptr+N; index arithmetic wraps naturally at W bits.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
      o_grant_idx   = '0;
      o_grant_valid = 1'b0;
      w_cand        = '0;
      for (int i = 1; i <= N; i++) begin
         w_cand = i_ptr + W'(i);
         if (!o_grant_valid && i_req[w_cand]) begin
            o_grant_idx   = w_cand;
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/packet_transfer_scheduler.sv
// Picks ready packet-buffer slots round-robin, holds each packet on the
// transfer interface until completion, then pulses the slot for release.
module packet_transfer_scheduler
   import packet_types::*;
#(
   parameter int NUM_SLOTS      = 8,
   parameter int IDX_W          = $clog2(NUM_SLOTS),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 nocclk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_SLOTS-1:0] slot_ready,
   output logic [IDX_W-1:0]     rd_idx,
   input  packet_element_t      rd_packet,
   output packet_element_t      transfered_packet,
   output logic                 transfered_packet_valid,
   input  logic                 transfered_packet_completed,
   output logic                 free_valid,
   output logic [IDX_W-1:0]     free_idx,
   output logic                 busy,
   output logic                 stall_error,
   output logic                 protocol_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   transfer_sched_state_t r_state;
   transfer_sched_state_t w_next_state;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic [IDX_W-1:0]      r_sel_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [NUM_SLOTS-1:0]  w_req;
   logic [IDX_W-1:0]      w_grant_idx;
   logic                  w_grant_valid;

   // Requests only count while idle; in BUSY/FREE nothing may be granted.
   assign w_req  = (r_state == IDLE) ? (slot_ready & {NUM_SLOTS{enable}}) : '0;
   assign rd_idx = w_grant_valid ? w_grant_idx : '0;
   assign busy   = (r_state != IDLE);

   packet_rr_arbiter #(
      .N (NUM_SLOTS),
      .W (IDX_W)
   ) u_arb (
      .i_req         (w_req),
      .i_ptr         (r_rr_ptr),
      .o_grant_idx   (w_grant_idx),
      .o_grant_valid (w_grant_valid)
   );

   // State register.
   always_ff @(posedge nocclk) begin
      // NOTE: reset is synchronous, so it is only sampled here on the clock edge.
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic: grant -> BUSY, completion -> FREE, FREE lasts one cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_grant_valid) w_next_state = BUSY;
         BUSY:    if (transfered_packet_completed) w_next_state = FREE;
         FREE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath: packet latch, release pulse, rr pointer, timeout and sticky errors.
   always_ff @(posedge nocclk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         transfered_packet       <= '0;
         transfered_packet_valid <= 1'b0;
         free_valid              <= 1'b0;
         free_idx                <= '0;
         r_sel_idx               <= '0;
         r_rr_ptr                <= IDX_W'(NUM_SLOTS - 1);
         r_cnt                   <= '0;
         stall_error             <= 1'b0;
         protocol_error          <= 1'b0;
      end else begin
         free_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (transfered_packet_completed) protocol_error <= 1'b1;
               if (w_grant_valid) begin
                  transfered_packet       <= rd_packet;
                  r_sel_idx               <= w_grant_idx;
                  transfered_packet_valid <= 1'b1;
               end
            end
            BUSY: begin
               if (transfered_packet_completed) begin
                  transfered_packet_valid <= 1'b0;
                  free_valid              <= 1'b1;
                  free_idx                <= r_sel_idx;
                  r_rr_ptr                <= r_sel_idx;
                  r_cnt                   <= '0;
               end else if (r_cnt != TIMEOUT_VAL) begin
                  // Counter saturates at the limit; the transfer itself is never aborted.
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == TIMEOUT_VAL - 1'b1) stall_error <= 1'b1;
               end
            end
            FREE: begin
               if (transfered_packet_completed) protocol_error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_transfer_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_packet_transfer_scheduler;
   import packet_types::*;

   localparam int N  = 8;
   localparam int T  = 16;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            enable;
   logic [N-1:0]    slot_ready;
   logic [IW-1:0]   rd_idx;
   packet_element_t rd_packet;
   packet_element_t transfered_packet;
   logic            valid;
   logic            completed;
   logic            free_valid;
   logic [IW-1:0]   free_idx;
   logic            busy;
   logic            stall_error;
   logic            protocol_error;

   packet_element_t mem [N];
   assign rd_packet = mem[rd_idx];

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   packet_transfer_scheduler #(
      .NUM_SLOTS      (N),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .nocclk                      (clk),
      .rst_n                       (rst_n),
      .enable                      (enable),
      .slot_ready                  (slot_ready),
      .rd_idx                      (rd_idx),
      .rd_packet                   (rd_packet),
      .transfered_packet           (transfered_packet),
      .transfered_packet_valid     (valid),
      .transfered_packet_completed (completed),
      .free_valid                  (free_valid),
      .free_idx                    (free_idx),
      .busy                        (busy),
      .stall_error                 (stall_error),
      .protocol_error              (protocol_error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Transaction view: a packet is either in flight, being released, or
   // nothing is happening; grants follow the round-robin rule from last served.
   function automatic int pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   bit              m_in_flight, m_releasing, m_stall, m_proto;
   int              m_last, m_slot, m_free_idx, m_busy_cycles;
   packet_element_t m_pkt;
   int              w_pick;

   assign w_pick = pick(slot_ready & {N{enable}}, m_last);

   always @(posedge clk) begin
      if (!rst_n) begin
         m_in_flight   <= 1'b0;
         m_releasing   <= 1'b0;
         m_stall       <= 1'b0;
         m_proto       <= 1'b0;
         m_last        <= N - 1;
         m_slot        <= 0;
         m_free_idx    <= 0;
         m_busy_cycles <= 0;
         m_pkt         <= '0;
      end else if (m_releasing) begin
         if (completed) m_proto <= 1'b1;
         m_releasing <= 1'b0;
      end else if (m_in_flight) begin
         if (completed) begin
            m_in_flight   <= 1'b0;
            m_releasing   <= 1'b1;
            m_free_idx    <= m_slot;
            m_last        <= m_slot;
            m_busy_cycles <= 0;
         end else begin
            if (m_busy_cycles < T) m_busy_cycles <= m_busy_cycles + 1;
            if (m_busy_cycles + 1 >= T) m_stall <= 1'b1;
         end
      end else begin
         if (completed) m_proto <= 1'b1;
         if (w_pick >= 0) begin
            m_pkt       <= mem[w_pick];
            m_slot      <= w_pick;
            m_in_flight <= 1'b1;
         end
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         int exp_rd;
         exp_rd = (!m_in_flight && !m_releasing && w_pick >= 0) ? w_pick : 0;
         check("valid",          64'(valid),             64'(m_in_flight));
         check("free_valid",     64'(free_valid),        64'(m_releasing));
         check("busy",           64'(busy),              64'(m_in_flight | m_releasing));
         check("free_idx",       64'(free_idx),          64'(m_free_idx));
         check("packet",         64'(transfered_packet), 64'(m_pkt));
         check("stall_error",    64'(stall_error),       64'(m_stall));
         check("protocol_error", 64'(protocol_error),    64'(m_proto));
         check("rd_idx",         64'(rd_idx),            64'(exp_rd));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!valid && n < 32) begin
         tick(1);
         n++;
      end
      check("wait_valid", 64'(valid), 64'd1);
   endtask

   int prev_freed = -1;

   // Wait for a grant, hold it `hold` cycles, complete, check the release.
   task automatic serve(input int exp_slot, input int hold);
      wait_valid();
      check("served_packet", 64'(transfered_packet), 64'(mem[exp_slot]));
      tick(hold - 1);
      completed = 1'b1;
      tick(1);
      completed = 1'b0;
      check("release_pulse", 64'(free_valid), 64'd1);
      check("release_idx",   64'(free_idx),   64'(exp_slot));
      if (prev_freed >= 0) check("no_repeat", 64'(free_idx != IW'(prev_freed)), 64'd1);
      prev_freed = int'(free_idx);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] r;
      for (int i = 0; i < N; i++) mem[i] = '{dest: 4'(i), length: 8'(8'h10 + i), data: 32'hA5A5_0000 + 32'(i)};
      rst_n      = 1'b0;
      enable     = 1'b1;
      slot_ready = 8'hFF;
      completed  = 1'b0;

      // Reset held two cycles with every slot ready: nothing granted.
      tick(2);
      chk_en = 1'b1;
      check("rst_valid",  64'(valid),             64'd0);
      check("rst_busy",   64'(busy),              64'd0);
      check("rst_free",   64'(free_valid),        64'd0);
      check("rst_pkt",    64'(transfered_packet), 64'd0);
      check("rst_errors", 64'({stall_error, protocol_error}), 64'd0);
      slot_ready = 8'h00;
      rst_n      = 1'b1;
      tick(1);

      // Single request from slot 2.
      slot_ready = 8'h04;
      tick(1);
      check("single_valid", 64'(valid), 64'd1);
      check("single_pkt",   64'(transfered_packet), 64'h0000_0212_A5A5_0002);
      tick(4);
      completed = 1'b1;
      tick(1);
      completed = 1'b0;
      check("single_free",     64'(free_valid), 64'd1);
      check("single_free_idx", 64'(free_idx),   64'd2);
      check("single_drop",     64'(valid),      64'd0);
      slot_ready = 8'h00;
      tick(1);
      check("single_idle", 64'({busy, free_valid}), 64'd0);

      // Fairness from a fresh pointer: 0..7 then 0.
      do_reset();
      prev_freed = -1;
      slot_ready = 8'hFF;
      for (int i = 0; i < 9; i++) serve(i % N, 3);

      // Wrap/skip: serve 6, then with 0 and 6 ready expect 0 then 6.
      slot_ready = 8'h40;
      tick(1);
      serve(6, 2);
      slot_ready = 8'h41;
      prev_freed = -1;
      serve(0, 1);
      serve(6, 1);
      slot_ready = 8'h00;
      tick(1);

      // Enable gating.
      enable     = 1'b0;
      slot_ready = 8'h01;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("disabled_no_valid", 64'(valid), 64'd0);
      end
      enable = 1'b1;
      tick(1);
      check("enabled_valid", 64'(valid), 64'd1);
      completed = 1'b1;
      tick(1);
      completed = 1'b0;
      check("enabled_free_idx", 64'(free_idx), 64'd0);
      slot_ready = 8'h00;
      tick(1);

      // Protocol error from a completion while idle; sticky.
      completed = 1'b1;
      tick(1);
      completed = 1'b0;
      check("proto_set", 64'(protocol_error), 64'd1);
      tick(2);
      check("proto_sticky", 64'(protocol_error), 64'd1);

      // Stall: completion withheld past the timeout.
      slot_ready = 8'h02;
      tick(1);
      check("stall_grant", 64'(valid), 64'd1);
      tick(15);
      check("stall_not_yet", 64'(stall_error), 64'd0);
      tick(1);
      check("stall_set",   64'(stall_error), 64'd1);
      check("stall_valid", 64'(valid),       64'd1);
      tick(3);
      completed = 1'b1;
      tick(1);
      completed = 1'b0;
      check("stall_freed",     64'(free_valid),  64'd1);
      check("stall_free_idx",  64'(free_idx),    64'd1);
      check("stall_sticky",    64'(stall_error), 64'd1);
      slot_ready = 8'h00;
      tick(1);

      // Randomized traffic, including occasional mid-transfer resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n      = ($urandom_range(0, 399) != 0);
         enable     = ($urandom_range(0, 7) != 0);
         slot_ready = N'($urandom);
         completed  = ($urandom_range(0, 4) == 0);
         r          = {$urandom(), $urandom()};
         mem[$urandom_range(0, N - 1)] = r[43:0];
         tick(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
